// File: rtl/kfps2kb_pkg.sv
// kfps2kb_pkg: decoder states, PS/2 control bytes and the Set-2 to Set-1
// translation used by the keyboard event queue.
// The optional extended-key (E0) path is enabled by defining KFPS2KB_EXTENDED_EN.
package kfps2kb_pkg;

    // Decoder state; the extended states only exist when E0 handling is built in.
`ifdef KFPS2KB_EXTENDED_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } dec_state_t;
`else
    typedef enum logic {
        ST_IDLE,
        ST_BREAK
    } dec_state_t;
`endif

    // Keyboard-to-host bytes that never represent a key.
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    // Prefix bytes.
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;

    // Set-2 make code 00..7F to Set-1 make code.
    localparam logic [7:0] SET1_TAB [128] = '{
        8'hFF, 8'h43, 8'h41, 8'h3F, 8'h3D, 8'h3B, 8'h3C, 8'h58, 8'h64, 8'h44, 8'h42, 8'h40, 8'h3E, 8'h0F, 8'h29, 8'h59,
        8'h65, 8'h38, 8'h2A, 8'h70, 8'h1D, 8'h10, 8'h02, 8'h5A, 8'h66, 8'h71, 8'h2C, 8'h1F, 8'h1E, 8'h11, 8'h03, 8'h5B,
        8'h67, 8'h2E, 8'h2D, 8'h20, 8'h12, 8'h05, 8'h04, 8'h5C, 8'h68, 8'h39, 8'h2F, 8'h21, 8'h14, 8'h13, 8'h06, 8'h5D,
        8'h69, 8'h31, 8'h30, 8'h23, 8'h22, 8'h15, 8'h07, 8'h5E, 8'h6A, 8'h72, 8'h32, 8'h24, 8'h16, 8'h08, 8'h09, 8'h5F,
        8'h6B, 8'h33, 8'h25, 8'h17, 8'h18, 8'h0B, 8'h0A, 8'h60, 8'h6C, 8'h34, 8'h35, 8'h26, 8'h27, 8'h19, 8'h0C, 8'h61,
        8'h6D, 8'h73, 8'h28, 8'h74, 8'h1A, 8'h0D, 8'h62, 8'h6E, 8'h3A, 8'h36, 8'h1C, 8'h1B, 8'h75, 8'h2B, 8'h63, 8'h76,
        8'h55, 8'h56, 8'h77, 8'h78, 8'h79, 8'h7A, 8'h0E, 8'h7B, 8'h7C, 8'h4F, 8'h7D, 8'h4B, 8'h47, 8'h7E, 8'h7F, 8'h6F,
        8'h52, 8'h53, 8'h50, 8'h4C, 8'h4D, 8'h48, 8'h01, 8'h45, 8'h57, 8'h4E, 8'h51, 8'h4A, 8'h37, 8'h49, 8'h46, 8'h54
    };

    // Upper half passes through unchanged except F7 (83), which Set 1 places at 41.
    function automatic logic [7:0] translate(input logic [7:0] code);
        logic [7:0] t;
        if (code[7]) begin
            t = (code == 8'h83) ? 8'h41 : code;
        end else begin
            t = SET1_TAB[code[6:0]];
        end
        return t;
    endfunction

endpackage

// File: rtl/kfps2kb_event_queue_if.sv
// kfps2kb_event_queue_if: receive strobes from the PS/2 shift register, pop
// strobe from the CPU side, and the queue status seen by the 8255/PIC path.
interface kfps2kb_event_queue_if #(
    parameter int FIFO_DEPTH = 8
) ();
    logic                        rx_valid;
    logic [7:0]                  rx_data;
    logic                        rx_error;
    logic                        clear_keycode;
    logic                        irq;
    logic [7:0]                  keycode;
    logic                        pause_core;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overrun;

    modport master (
        output rx_valid, rx_data, rx_error, clear_keycode,
        input  irq, keycode, pause_core, fifo_count, overrun
    );

    modport slave (
        input  rx_valid, rx_data, rx_error, clear_keycode,
        output irq, keycode, pause_core, fifo_count, overrun
    );
endinterface

// File: rtl/kfps2kb_fifo.sv
// kfps2kb_fifo: byte FIFO with registered head/non-empty outputs, occupancy
// count, and an overwrite path that replaces the newest entry when a push
// arrives while full without a matching pop. Sticky overrun flag included.
module kfps2kb_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [7:0]  i_wdata,
    input  logic [7:0]  i_ovw_data,
    output logic [7:0]  o_head,
    output logic        o_nonempty,
    output logic [AW:0] o_count,
    output logic        o_overrun
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic [7:0]    r_head;
    logic          r_nonempty;

    logic          w_empty;
    logic          w_full;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic          w_ovf;
    logic [AW-1:0] w_ovw_addr;
    logic [AW-1:0] w_rd_nxt;
    logic [AW:0]   w_count_nxt;
    logic [7:0]    w_head_nxt;

    // Accept/overflow decisions and the head value visible after this edge.
    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == FULL_CNT);
        w_pop_ok    = i_pop && !w_empty;
        w_push_ok   = i_push && (!w_full || w_pop_ok);
        w_ovf       = i_push && w_full && !w_pop_ok;
        w_ovw_addr  = r_wr_ptr - 1'b1;
        w_rd_nxt    = w_pop_ok ? (r_rd_ptr + 1'b1) : r_rd_ptr;
        w_count_nxt = r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
        w_head_nxt  = 8'h00;
        if (w_count_nxt != '0) begin
            // Bypass the slot being written this cycle so the head is never stale.
            if (w_push_ok && (w_rd_nxt == r_wr_ptr)) begin
                w_head_nxt = i_wdata;
            end else if (w_ovf && (w_rd_nxt == w_ovw_addr)) begin
                w_head_nxt = i_ovw_data;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
        if (w_ovf) begin
            r_mem[w_ovw_addr] <= i_ovw_data;
        end
    end

    // Pointers, occupancy, sticky overrun and registered head/non-empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_head     <= 8'h00;
            r_nonempty <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_count_nxt;
            r_head     <= w_head_nxt;
            r_nonempty <= (w_count_nxt != '0);
            if (w_ovf) begin
                r_overrun <= 1'b1;
            end else if (w_pop_ok && !w_push_ok && (r_count == ONE_CNT)) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_head     = r_head;
    assign o_nonempty = r_nonempty;
    assign o_count    = r_count;
    assign o_overrun  = r_overrun;
endmodule

// File: rtl/kfps2kb_event_queue.sv
// kfps2kb_event_queue: Set-2 prefix decoder, Set-1 translation, keystroke FIFO
// and pause-core toggle between the PS/2 receiver and the XT keyboard path.
// Define KFPS2KB_EXTENDED_EN to queue E0 prefixes and track extended keys;
// otherwise E0 is ignored and extended keys alias to their base codes.
module kfps2kb_event_queue
    import kfps2kb_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] PAUSE_CODE = 8'h07,
    parameter logic [7:0] ERROR_CODE = 8'hFF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    kfps2kb_event_queue_if.slave bus
);
    dec_state_t r_state;
    dec_state_t w_state_nxt;
    logic       r_pause;
    logic       w_pause_tgl;
    logic       w_push;
    logic [7:0] w_push_data;
    logic       w_is_ctrl;
    logic       w_in_break;

    // Decoder state and pause flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pause <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pause_tgl) begin
                r_pause <= ~r_pause;
            end
        end
    end

    // Next decoder state, pause toggle and the byte to enqueue for this strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_pause_tgl = 1'b0;
        w_push      = 1'b0;
        w_push_data = 8'h00;
        w_is_ctrl   = (bus.rx_data == PS2_ACK)  || (bus.rx_data == PS2_BAT) ||
                      (bus.rx_data == PS2_ECHO) || (bus.rx_data == PS2_RESEND);
`ifdef KFPS2KB_EXTENDED_EN
        w_in_break  = (r_state == ST_BREAK) || (r_state == ST_EXT_BREAK);
`else
        w_in_break  = (r_state == ST_BREAK);
`endif
        if (bus.rx_error) begin
            // Errors are reported unless the core is paused.
            w_state_nxt = ST_IDLE;
            if (!r_pause) begin
                w_push      = 1'b1;
                w_push_data = ERROR_CODE;
            end
        end else if (bus.rx_valid) begin
            if (w_is_ctrl) begin
                w_state_nxt = ST_IDLE;
            end else if (bus.rx_data == PS2_BREAK) begin
                // F0 is still honoured while paused so the unpause release can be seen.
                if (r_state == ST_IDLE) begin
                    w_state_nxt = ST_BREAK;
`ifdef KFPS2KB_EXTENDED_EN
                end else if (r_state == ST_EXT) begin
                    w_state_nxt = ST_EXT_BREAK;
`endif
                end
            end else if ((bus.rx_data == PAUSE_CODE) && (r_state == ST_BREAK)) begin
                w_pause_tgl = 1'b1;
                w_state_nxt = ST_IDLE;
            end else if ((bus.rx_data == PAUSE_CODE) && (r_state == ST_IDLE)) begin
                w_state_nxt = ST_IDLE;
            end else if (r_pause) begin
                w_state_nxt = ST_IDLE;
            end else if (bus.rx_data == PS2_EXT) begin
`ifdef KFPS2KB_EXTENDED_EN
                w_push      = 1'b1;
                w_push_data = PS2_EXT;
                if (r_state == ST_IDLE) begin
                    w_state_nxt = ST_EXT;
                end else if (r_state == ST_BREAK) begin
                    w_state_nxt = ST_EXT_BREAK;
                end
`endif
            end else begin
                w_push      = 1'b1;
                w_push_data = translate(bus.rx_data) | (w_in_break ? 8'h80 : 8'h00);
                w_state_nxt = ST_IDLE;
            end
        end
    end

    kfps2kb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clock),
        .i_rst_n    (reset_n),
        .i_push     (w_push),
        .i_pop      (bus.clear_keycode),
        .i_wdata    (w_push_data),
        .i_ovw_data (ERROR_CODE),
        .o_head     (bus.keycode),
        .o_nonempty (bus.irq),
        .o_count    (bus.fifo_count),
        .o_overrun  (bus.overrun)
    );

    assign bus.pause_core = r_pause;
endmodule

// File: doc/kfps2kb_event_queue.md
Name: kfps2kb_event_queue

Overview:
- Parametrised successor to the single-register PS/2 keycode stage.
- Accepts decoded Set-2 bytes from the PS/2 shift register and tracks F0 (break) and E0 (extended) prefixes.
- Translates each code to Set 1 and buffers the results in a FIFO of configurable depth, so no keystroke is lost while the CPU services the interrupt.
- Sits between the PS/2 shift register and the 8255/PIC keyboard path of the XT core. It also owns the pause-core toggle.

Parameters:
- FIFO_DEPTH, 8: queue entries. Power of two, ≥2.
- PAUSE_CODE, 8'h07: Set-2 code whose release toggles pause_core.
- ERROR_CODE, 8'hFF: byte queued on receive error or overrun.

Ports:
- clock, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- rx_valid, input, 1: one-cycle strobe; rx_data is valid.
- rx_data, input, 8: received Set-2 byte.
- rx_error, input, 1: one-cycle strobe; parity, framing or timeout error.
- clear_keycode, input, 1: one-cycle pop of the head entry.
- irq, output, 1: high while the queue is non-empty.
- keycode, output, 8: head entry; 8'h00 when empty.
- pause_core, output, 1: core pause request.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: occupancy.
- overrun, output, 1: sticky; a push occurred while the queue was full.

Behaviour:
- Reset (reset_n low, async): irq=0, keycode=8'h00, pause_core=0, fifo_count=0, overrun=0, decoder state=IDLE, pointers=0.
- Decoder FSM states: IDLE, BREAK, EXT, EXT_BREAK. It is evaluated only on rx_valid or rx_error.
- rx_error takes priority over rx_valid. It pushes ERROR_CODE and sets state to IDLE.
- rx_data FA, AA, EE, FE (ACK, BAT, echo, resend): nothing pushed; state to IDLE.
- rx_data F0: IDLE→BREAK, EXT→EXT_BREAK. Nothing pushed.
- rx_data E0: see Optional Feature.
- rx_data == PAUSE_CODE in IDLE: dropped.
- rx_data == PAUSE_CODE in BREAK: toggles pause_core. Nothing pushed. State to IDLE.
- While pause_core=1: every other byte is dropped (including E0 and error) and state goes to IDLE. The FIFO is not flushed.
- Any other byte: push translate(rx_data) | (state∈{BREAK,EXT_BREAK} ? 8'h80 : 8'h00). State to IDLE.
- Latency: strobe at cycle N → irq/keycode/fifo_count updated at N+1. keycode and irq are registered.
- Pop: clear_keycode with the queue non-empty advances the head; the new keycode appears at N+1. clear_keycode on an empty queue is ignored.
- Simultaneous push and pop:
  - Queue full: pop frees the slot, push is accepted, overrun is unaffected, count unchanged.
  - Queue empty: push is accepted, pop is ignored.
- Push while full and no pop: the incoming byte is discarded, the newest stored entry is overwritten with ERROR_CODE, and overrun=1.
- overrun clears when a pop leaves the queue empty.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- A rising reset_n mid-sequence (e.g. after F0) restarts in IDLE.

Optional Feature:
- Macro: KFPS2KB_EXTENDED_EN.
- Defined:
  - E0 in IDLE pushes 8'hE0 and moves to EXT.
  - E0 in BREAK pushes 8'hE0 and moves to EXT_BREAK.
  - The following code is translated normally, giving the Set-1 E0-prefixed sequence (e.g. E0 F0 75 → E0, C8).
- Not defined:
  - E0 is silently dropped and the state is unchanged.
  - EXT and EXT_BREAK are unreachable and are removed.
  - Extended keys alias to their base codes.

Decomposition:
- Package kfps2kb_pkg holds:
  - the decoder state enum;
  - constants PS2_ACK/BAT/ECHO/RESEND/BREAK/EXT;
  - the Set-2→Set-1 translate function: 00→FF, 83→41 (F7), identity above 8'h8F.
- One sub-module: kfps2kb_fifo, a parametrised synchronous FIFO with a full-overwrite port and count output.

Test Plan:
- Reset, then rx 1C → after one cycle irq=1, keycode=1E, fifo_count=1; clear_keycode → irq=0, keycode=00.
- rx F0, 1C, FA → single entry 9E. FA is not queued. State returns to IDLE.
- Depth 8: push 9 makes (15,16,…), no pops → fifo_count=8, overrun=1, entry 8 reads FF. Draining all 8 entries clears overrun.
- Queue full, same-cycle rx 1D and clear_keycode → count stays 8, overrun=0, last entry 11.
- rx 07 → nothing queued. rx F0, 07 → pause_core=1. rx 1C → dropped. rx F0, 07 → pause_core=0.
- With KFPS2KB_EXTENDED_EN: rx E0, F0, 75 → queue E0, C8. Without the macro: queue C8 only.
